uart_tx_arbiter: RTL

//  Shares one UART transmitter (i_data/i_we/o_busy byte interface) among N byte-stream requesters.

---
 rtl/uart_tx_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte-wide UART transmitter among N message sources.
// A grant is held for a whole message (or MAX_PKT bytes) so messages never interleave.

module uart_tx_arb_lane #(
  parameter int K  = 0,
  parameter int OW = 2
) (
  input  logic          in_load,
  input  logic [OW-1:0] owner,
  input  logic          valid,
  input  logic [7:0]    data,
  input  logic          last,
  output logic          ready,
  output logic [7:0]    data_m,
  output logic          last_m
);
  localparam logic [OW-1:0] KID = OW'(K);
  logic own;

  assign own    = (owner == KID);
  assign ready  = in_load & own & valid;
  assign data_m = own ? data : 8'h00;
  assign last_m = own & last;
endmodule

module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int MAX_PKT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N-1:0]         i_valid,
  input  logic [8*N-1:0]       i_data,
  input  logic [N-1:0]         i_last,
  output logic [N-1:0]         o_ready,
  output logic [7:0]           o_uart_data,
  output logic                 o_uart_we,
  input  logic                 i_uart_busy,
  output logic [$clog2(N)-1:0] o_owner,
  output logic                 o_active
);
  localparam int OW = $clog2(N);
  localparam int CW = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_GAP, S_WAIT} state_t;

  state_t        state, state_d;
  logic [OW-1:0] owner, owner_d, ptr, ptr_d, grant_idx;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0]    data_q, data_d, sel_data;
  logic          last_q, last_d, sel_last, grant_hit, accept, we, in_load;

  logic [N-1:0]       lane_last;
  logic [N-1:0][7:0]  lane_data;

  assign in_load = (state == S_LOAD);

  for (genvar k = 0; k < N; k++) begin : g_lane
    uart_tx_arb_lane #(.K(k), .OW(OW)) u_lane (
      .in_load (in_load),
      .owner   (owner),
      .valid   (i_valid[k]),
      .data    (i_data[8*k +: 8]),
      .last    (i_last[k]),
      .ready   (o_ready[k]),
      .data_m  (lane_data[k]),
      .last_m  (lane_last[k])
    );
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      sel_data = sel_data | lane_data[k];
      sel_last = sel_last | lane_last[k];
    end
  end

  assign accept = |o_ready;

  // Rotating search from ptr; iterate far-to-near so the nearest requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_hit = 1'b0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (i_valid[idx]) begin
        grant_hit = 1'b1;
        grant_idx = OW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state;
    owner_d = owner;
    ptr_d   = ptr;
    cnt_d   = cnt;
    data_d  = data_q;
    last_d  = last_q;
    we      = 1'b0;
    case (state)
      S_IDLE: if (grant_hit) begin
        owner_d = grant_idx;
        cnt_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: if (accept) begin
        data_d  = sel_data;
        last_d  = sel_last;
        state_d = S_ISSUE;
      end
      S_ISSUE: if (!i_uart_busy) begin
        we      = 1'b1;
        state_d = S_GAP;
      end
      // Busy from the UART may lag the strobe by a cycle, so it is not trusted here.
      S_GAP: state_d = S_WAIT;
      S_WAIT: if (!i_uart_busy) begin
        if (last_q || cnt == CW'(MAX_PKT - 1)) begin
          ptr_d   = (owner == OW'(N - 1)) ? '0 : owner + 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt + 1'b1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      owner  <= '0;
      ptr    <= '0;
      cnt    <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      state  <= state_d;
      owner  <= owner_d;
      ptr    <= ptr_d;
      cnt    <= cnt_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

  assign o_uart_we   = we;
  assign o_uart_data = data_q;
  assign o_owner     = owner;
  assign o_active    = (state != S_IDLE);
endmodule
